// File: rtl/sar_search.sv
// Binary-search initiator: presents probe values to an external magnitude
// comparator and narrows [lo, hi] on each eq/lt/gt reply until it converges.
module sar_search #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             cmp_valid,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] probe_count
);

  // Bounds carry one extra bit so lo can reach 2^WIDTH and hi can reach -1.
  localparam int unsigned BW = WIDTH + 1;
  localparam logic [BW-1:0]    HI_INIT    = BW'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] PROBE_INIT = WIDTH'((1 << (WIDTH - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] lo;
  logic [BW-1:0] hi;

  logic [BW-1:0]    lo_n;
  logic [BW-1:0]    hi_n;
  logic [BW-1:0]    span;
  logic [BW-1:0]    mid;
  logic [WIDTH-1:0] probe_n;
  logic             empty_c;
  logic             legal_c;
  logic             start_ok;

  // Candidate bounds and next probe assuming the current reply is accepted.
  always_comb begin
    lo_n = lo;
    hi_n = hi;
    if (lt) lo_n = BW'(probe) + BW'(1);
    if (gt) hi_n = BW'(probe) - BW'(1);
    // hi never exceeds 2^WIDTH-1, so its top bit marks underflow below zero.
    empty_c = $signed({1'b0, lo_n}) > $signed({hi_n[BW-1], hi_n});
    span    = hi_n - lo_n;
    mid     = lo_n + (span >> 1);
    probe_n = WIDTH'(mid);
    legal_c = $onehot({eq, lt, gt});
  end

  // A start coinciding with the done pulse is deliberately dropped.
  assign start_ok = start && ((state == IDLE) || ((state == DONE) && !done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lo          <= '0;
      hi          <= HI_INIT;
      probe       <= '0;
      probe_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      probe_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        PROBE: begin
          if (cmp_valid) begin
            probe_count <= probe_count + CNT_W'(1);
            if (!legal_c) begin
              err         <= 1'b1;
              found       <= 1'b0;
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              probe_valid <= 1'b0;
            end else if (eq) begin
              result      <= probe;
              found       <= 1'b1;
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              probe_valid <= 1'b0;
            end else begin
              lo <= lo_n;
              hi <= hi_n;
              if (empty_c) begin
                found       <= 1'b0;
                state       <= DONE;
                done        <= 1'b1;
                busy        <= 1'b0;
                probe_valid <= 1'b0;
              end else begin
                probe <= probe_n;
              end
            end
          end
        end
        default: begin
          if (start_ok) begin
            lo          <= '0;
            hi          <= HI_INIT;
            probe       <= PROBE_INIT;
            probe_count <= '0;
            found       <= 1'b0;
            err         <= 1'b0;
            probe_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= PROBE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: a behavioural comparator answers probes and
// each search's probe sequence and final status are checked against hand values.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] probe;
  logic       probe_valid;
  logic       cmp_valid;
  logic       eq;
  logic       lt;
  logic       gt;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [3:0] result;
  logic [2:0] probe_count;

  int errors = 0;
  int checks = 0;
  int exp_probes[$];

  sar_search #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .probe       (probe),
    .probe_valid (probe_valid),
    .cmp_valid   (cmp_valid),
    .eq          (eq),
    .lt          (lt),
    .gt          (gt),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .err         (err),
    .result      (result),
    .probe_count (probe_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_probe"}, int'(probe), 0);
    check({tag, "_pvalid"}, int'(probe_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_count"}, int'(probe_count), 0);
  endtask

  // mode: 0 honest comparator, 1 always lt, 2 eq+gt, 3 no flag set.
  task automatic run_search(input string tag, input int tgt, input int dly, input int mode,
                            input int x_found, input int x_err, input int x_result,
                            input int x_count);
    int n = 0;
    int guard = 0;
    int held;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!done && guard < 200) begin
      cmp_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
      if (probe_valid) begin
        held = int'(probe);
        for (int w = 0; w < dly; w++) begin
          start = 1'b1;
          @(negedge clk);
          check({tag, "_hold"}, int'(probe), held);
          check({tag, "_busy_wait"}, int'(busy), 1);
        end
        start = 1'b0;
        if (n < exp_probes.size()) check({tag, "_probe"}, int'(probe), exp_probes[n]);
        n++;
        cmp_valid = 1'b1;
        case (mode)
          0: begin
            eq = (int'(probe) == tgt);
            lt = (int'(probe) < tgt);
            gt = (int'(probe) > tgt);
          end
          1: lt = 1'b1;
          2: begin eq = 1'b1; gt = 1'b1; end
          default: ;
        endcase
      end
      @(negedge clk);
      guard++;
    end
    cmp_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
    check({tag, "_timeout"}, int'(guard < 200), 1);
    check({tag, "_nprobes"}, n, exp_probes.size());
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pvalid"}, int'(probe_valid), 0);
    check({tag, "_found"}, int'(found), x_found);
    check({tag, "_err"}, int'(err), x_err);
    if (x_found != 0) check({tag, "_result"}, int'(result), x_result);
    check({tag, "_count"}, int'(probe_count), x_count);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_found_hold"}, int'(found), x_found);
    check({tag, "_count_hold"}, int'(probe_count), x_count);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    cmp_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    exp_probes = '{7, 11, 13, 12};
    run_search("t12", 12, 0, 0, 1, 0, 12, 4);

    exp_probes = '{7, 3, 1, 0};
    run_search("t0", 0, 0, 0, 1, 0, 0, 4);

    exp_probes = '{7, 11, 13, 14, 15};
    run_search("t15", 15, 0, 0, 1, 0, 15, 5);

    exp_probes = '{7, 11, 13, 14, 15};
    run_search("all_lt", 0, 0, 1, 0, 0, 0, 5);

    exp_probes = '{7};
    run_search("eq_gt", 7, 0, 2, 0, 1, 0, 1);

    exp_probes = '{7};
    run_search("no_flag", 7, 0, 3, 0, 1, 0, 1);

    exp_probes = '{7, 3, 5};
    run_search("t5_slow", 5, 3, 0, 1, 0, 5, 3);

    // Abort during the second probe with an asynchronous reset.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rst_first_probe", int'(probe), 7);
    cmp_valid = 1'b1; lt = 1'b1;
    @(negedge clk);
    cmp_valid = 1'b0; lt = 1'b0;
    check("rst_second_probe", int'(probe), 11);
    check("rst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    check("mid_reset_no_done", int'(done), 0);
    rst_n = 1'b1;

    exp_probes = '{7, 11, 9};
    run_search("t9", 9, 0, 0, 1, 0, 9, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
